// File: rtl/lsu_rmw_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state
// type and the lane-merge helper used by sub-word stores.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, WRITE} lsu_state_t;

  // Replace one byte or halfword lane of a memory word with store data.
  // The lane is chosen by the low address bits; halfwords use bit 1 only.
  function automatic logic [31:0] mergeLane(input logic [31:0] word,
                                            input logic [15:0] data,
                                            input logic [1:0]  off,
                                            input logic        isHalf);
    logic [31:0] res;
    res = word;
    if (isHalf) begin
      if (off[1]) res[31:16] = data;
      else        res[15:0]  = data;
    end else begin
      case (off)
        2'd0:    res[7:0]   = data[7:0];
        2'd1:    res[15:8]  = data[7:0];
        2'd2:    res[23:16] = data[7:0];
        default: res[31:24] = data[7:0];
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// Core-side request/response and dmem-side bus of the load/store unit.
// The slave modport is the LSU itself; the master modport is the environment
// (core datapath plus data memory) that drives requests and read data.
interface lsu_rmw_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  req;
  logic                  wr;
  logic [2:0]            funct3;
  logic [31:0]           addr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  stall;
  logic                  misalign;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic [31:0]           mem_wd;
  logic [31:0]           mem_rd;

  modport slave (
    input  req, wr, funct3, addr, wdata, mem_rd,
    output rdata, stall, misalign, mem_we, mem_a, mem_wd
  );

  modport master (
    output req, wr, funct3, addr, wdata, mem_rd,
    input  rdata, stall, misalign, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/lsu_rmw_load_align.sv
// Combinational load extraction: picks the byte/half lane out of the dmem
// word and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rd_i,
  input  logic [1:0]  byte_off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Lane selection followed by extension; unsupported encodings read as 0.
  always_comb begin
    byteSel = 8'h00;
    halfSel = 16'h0000;
    rdata_o = '0;
    case (byte_off_i)
      2'd0:    byteSel = mem_rd_i[7:0];
      2'd1:    byteSel = mem_rd_i[15:8];
      2'd2:    byteSel = mem_rd_i[23:16];
      default: byteSel = mem_rd_i[31:24];
    endcase
    halfSel = byte_off_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (funct3_i)
      F3_B:    rdata_o = {{24{byteSel[7]}}, byteSel};
      F3_BU:   rdata_o = {24'h000000, byteSel};
      F3_H:    rdata_o = {{16{halfSel[15]}}, halfSel};
      F3_HU:   rdata_o = {16'h0000, halfSel};
      F3_W:    rdata_o = mem_rd_i;
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit between the core and a word-only data memory. Loads and
// word stores complete in one cycle; byte/half stores need a read-modify-
// write over two cycles because dmem has no byte enables, and the core is
// stalled for the first of them.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic      clk,
  input  logic      reset,
  lsu_rmw_if.slave  bus
);

  lsu_state_t  state_q, state_d;
  logic [31:0] merge_q, merge_d;

  logic [31:0] loadData;
  logic        misalignRaw;
  logic        stallW;
  logic        weW;
  logic        misalignW;
  logic [31:0] rdataW;
  logic        unusedBits;

  assign unusedBits = ^bus.addr[31:ADDR_WIDTH+2];

  lsu_load_align uAlign (
    .mem_rd_i   (bus.mem_rd),
    .byte_off_i (bus.addr[1:0]),
    .funct3_i   (bus.funct3),
    .rdata_o    (loadData)
  );

  // Alignment and encoding check; any hit suppresses the whole access.
  always_comb begin
    misalignRaw = 1'b0;
    if (bus.funct3 == 3'b011 || bus.funct3[2:1] == 2'b11)
      misalignRaw = 1'b1;
    else if (bus.funct3[1:0] == 2'b01 && bus.addr[0])
      misalignRaw = 1'b1;
    else if (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00)
      misalignRaw = 1'b1;
  end

  // Next-state and output decode; reset blanks every output so that a
  // reset landing on the WRITE cycle never commits a partial write.
  always_comb begin
    state_d   = state_q;
    merge_d   = merge_q;
    stallW    = 1'b0;
    weW       = 1'b0;
    misalignW = 1'b0;
    rdataW    = '0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (bus.req && misalignRaw) begin
            misalignW = 1'b1;
          end else if (bus.req && !bus.wr) begin
            rdataW = loadData;
          end else if (bus.req && bus.funct3[1:0] == 2'b10) begin
            weW = 1'b1;
          end else if (bus.req) begin
            stallW  = 1'b1;
            merge_d = mergeLane(bus.mem_rd, bus.wdata[15:0], bus.addr[1:0],
                                bus.funct3[0]);
            state_d = WRITE;
          end
        end
        WRITE: begin
          weW     = bus.req;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state and merged store word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
    end
  end

  assign bus.mem_a    = bus.addr[ADDR_WIDTH+1:2];
  assign bus.mem_wd   = (state_q == WRITE) ? merge_q : bus.wdata;
  assign bus.mem_we   = weW;
  assign bus.stall    = stallW;
  assign bus.misalign = misalignW;
  assign bus.rdata    = rdataW;

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw: a table of single-cycle load/store
// vectors plus hand-written multi-cycle store, abort and reset sequences.
// Each driven cycle pushes its expected outputs; a negedge checker pops them.
module tb_lsu_rmw;
  import lsu_pkg::*;

  localparam int AW = 6;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        misalign;
    logic        stall;
    logic        memWe;
    logic [31:0] memWd;
  } expect_t;

  typedef struct {
    string       name;
    logic        req;
    logic        wr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expMisalign;
    logic        expWe;
    logic [31:0] expWd;
  } vec_t;

  logic clk;
  logic reset;
  logic preloadEn;
  logic [AW-1:0] preloadA;
  logic [31:0] preloadD;
  logic [31:0] dmem [0:(1<<AW)-1];

  expect_t expQ[$];
  int assertCount;
  int failCount;
  vec_t vecs [18];

  lsu_rmw_if #(.ADDR_WIDTH(AW)) bus();

  lsu_rmw #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word-only data memory with combinational read and a backdoor preload.
  always @(posedge clk) begin
    if (preloadEn) dmem[preloadA] <= preloadD;
    else if (bus.mem_we) dmem[bus.mem_a] <= bus.mem_wd;
  end
  assign bus.mem_rd = dmem[bus.mem_a];

  task automatic checkField(input string name, input string field,
                            input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s.%s actual=0x%08h expected=0x%08h", name, field, act, exp);
    end
  endtask

  // Pop one expected record and compare it with the current DUT outputs.
  task automatic checkOutput();
    expect_t e;
    e = expQ.pop_front();
    checkField(e.name, "rdata", bus.rdata, e.rdata);
    checkField(e.name, "misalign", {31'b0, bus.misalign}, {31'b0, e.misalign});
    checkField(e.name, "stall", {31'b0, bus.stall}, {31'b0, e.stall});
    checkField(e.name, "mem_we", {31'b0, bus.mem_we}, {31'b0, e.memWe});
    if (e.memWe) checkField(e.name, "mem_wd", bus.mem_wd, e.memWd);
  endtask

  // Outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (expQ.size() != 0) checkOutput();
  end

  // Drive one cycle of stimulus just after the rising edge and queue the
  // outputs expected for that cycle.
  task automatic applyStimulus(input string name, input logic rst,
                               input logic rq, input logic w,
                               input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] expRd,
                               input logic expMis, input logic expStall,
                               input logic expWe, input logic [31:0] expWd);
    expect_t e;
    @(posedge clk);
    #1;
    reset      = rst;
    bus.req    = rq;
    bus.wr     = w;
    bus.funct3 = f3;
    bus.addr   = a;
    bus.wdata  = wd;
    e.name     = name;
    e.rdata    = expRd;
    e.misalign = expMis;
    e.stall    = expStall;
    e.memWe    = expWe;
    e.memWd    = expWd;
    expQ.push_back(e);
  endtask

  task automatic preload(input logic [31:0] byteAddr, input logic [31:0] data);
    @(posedge clk);
    #1;
    preloadEn = 1'b1;
    preloadA  = byteAddr[AW+1:2];
    preloadD  = data;
    @(posedge clk);
    #1;
    preloadEn = 1'b0;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    preloadEn   = 1'b0;
    preloadA    = '0;
    preloadD    = '0;
    bus.req     = 1'b0;
    bus.wr      = 1'b0;
    bus.funct3  = F3_W;
    bus.addr    = '0;
    bus.wdata   = '0;

    vecs[0]  = '{"LB a0",    1'b1, 1'b0, F3_B,   32'h00, 32'h0, 32'h0000_0001, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{"LB a1",    1'b1, 1'b0, F3_B,   32'h01, 32'h0, 32'h0000_007F, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{"LB a2",    1'b1, 1'b0, F3_B,   32'h02, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{"LB a3",    1'b1, 1'b0, F3_B,   32'h03, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{"LBU a3",   1'b1, 1'b0, F3_BU,  32'h03, 32'h0, 32'h0000_0080, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{"LBU a2",   1'b1, 1'b0, F3_BU,  32'h02, 32'h0, 32'h0000_00FF, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{"LH a0",    1'b1, 1'b0, F3_H,   32'h00, 32'h0, 32'h0000_7F01, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{"LH a2",    1'b1, 1'b0, F3_H,   32'h02, 32'h0, 32'hFFFF_80FF, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{"LHU a2",   1'b1, 1'b0, F3_HU,  32'h02, 32'h0, 32'h0000_80FF, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{"LH a1",    1'b1, 1'b0, F3_H,   32'h01, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{"LW a0",    1'b1, 1'b0, F3_W,   32'h00, 32'h0, 32'h80FF_7F01, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{"LW a2",    1'b1, 1'b0, F3_W,   32'h02, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0};
    vecs[12] = '{"LD f3011", 1'b1, 1'b0, 3'b011, 32'h00, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{"LD f3110", 1'b1, 1'b0, 3'b110, 32'h00, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0};
    vecs[14] = '{"noreq",    1'b0, 1'b0, F3_W,   32'h00, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{"SW a30",   1'b1, 1'b1, F3_W,   32'h30, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D};
    vecs[16] = '{"LW a30",   1'b1, 1'b0, F3_W,   32'h30, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0};
    vecs[17] = '{"SW a22",   1'b1, 1'b1, F3_W,   32'h22, 32'h5555_5555, 32'h0, 1'b1, 1'b0, 32'h0};

    preload(32'h00, 32'h80FF_7F01);
    preload(32'h10, 32'h1122_3344);
    preload(32'h20, 32'hDEAD_BEEF);

    // Reset with a word store presented: everything must stay quiet.
    applyStimulus("reset", 1'b1, 1'b1, 1'b1, F3_W, 32'h00, 32'hFFFF_FFFF,
                  32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 18; i++)
      applyStimulus(vecs[i].name, 1'b0, vecs[i].req, vecs[i].wr, vecs[i].funct3,
                    vecs[i].addr, vecs[i].wdata, vecs[i].expRdata,
                    vecs[i].expMisalign, 1'b0, vecs[i].expWe, vecs[i].expWd);

    // SB lane 2 then read back.
    applyStimulus("SB12 c1", 1'b0, 1'b1, 1'b1, F3_B, 32'h12, 32'h0000_00AB,
                  32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus("SB12 c2", 1'b0, 1'b1, 1'b1, F3_B, 32'h12, 32'h0000_00AB,
                  32'h0, 1'b0, 1'b0, 1'b1, 32'h11AB_3344);
    applyStimulus("SB12 LW", 1'b0, 1'b1, 1'b0, F3_W, 32'h10, 32'h0,
                  32'h11AB_3344, 1'b0, 1'b0, 1'b0, 32'h0);

    // SB lane 3 with junk in the upper store-data bits, back to back.
    applyStimulus("SB13 c1", 1'b0, 1'b1, 1'b1, F3_B, 32'h13, 32'h5555_55CD,
                  32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus("SB13 c2", 1'b0, 1'b1, 1'b1, F3_B, 32'h13, 32'h5555_55CD,
                  32'h0, 1'b0, 1'b0, 1'b1, 32'hCDAB_3344);

    // SH low half, readback, misaligned SW to same word, SH upper half.
    applyStimulus("LW20 pre", 1'b0, 1'b1, 1'b0, F3_W, 32'h20, 32'h0,
                  32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("SH20 c1", 1'b0, 1'b1, 1'b1, F3_H, 32'h20, 32'h0000_1234,
                  32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus("SH20 c2", 1'b0, 1'b1, 1'b1, F3_H, 32'h20, 32'h0000_1234,
                  32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_1234);
    applyStimulus("SW22 mis", 1'b0, 1'b1, 1'b1, F3_W, 32'h22, 32'h0BAD_0BAD,
                  32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus("SH20 LW", 1'b0, 1'b1, 1'b0, F3_W, 32'h20, 32'h0,
                  32'hDEAD_1234, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("SH22 c1", 1'b0, 1'b1, 1'b1, F3_H, 32'h22, 32'hFFFF_9876,
                  32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus("SH22 c2", 1'b0, 1'b1, 1'b1, F3_H, 32'h22, 32'hFFFF_9876,
                  32'h0, 1'b0, 1'b0, 1'b1, 32'h9876_1234);

    // Abort: request dropped in the WRITE cycle, word must be untouched.
    applyStimulus("ABT c1", 1'b0, 1'b1, 1'b1, F3_B, 32'h10, 32'h0000_0077,
                  32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus("ABT c2", 1'b0, 1'b0, 1'b1, F3_B, 32'h10, 32'h0000_0077,
                  32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("ABT LW", 1'b0, 1'b1, 1'b0, F3_W, 32'h10, 32'h0,
                  32'hCDAB_3344, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset landing on the WRITE cycle of an SB.
    applyStimulus("RST c1", 1'b0, 1'b1, 1'b1, F3_B, 32'h20, 32'h0000_0099,
                  32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus("RST c2", 1'b1, 1'b1, 1'b1, F3_B, 32'h20, 32'h0000_0099,
                  32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("RST LW", 1'b0, 1'b1, 1'b0, F3_W, 32'h20, 32'h0,
                  32'h9876_1234, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("RST LHU", 1'b0, 1'b1, 1'b0, F3_HU, 32'h22, 32'h0,
                  32'h0000_9876, 1'b0, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
    #1;
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain pending=%0d expected=0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
